// File: rtl/arm_lp_pkg.sv
// Shared ARM-LP pipeline types and constants: instruction width, default
// address width, the NOP encoding and the fetch-stage state encoding.
package arm_lp_pkg;

  localparam int INSTR_WIDTH        = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  // FILL: nothing in flight or IF/ID just flushed; RUN: streaming;
  // HOLD: stalled with one response parked in the hold buffer.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target adder: branch PC plus a sign-extended word offset scaled to bytes.
// Purely combinational; shared with the execute-stage branch unit.
module branch_target_calc #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] branch_pc_i,
  input  logic [31:0]           branch_offset_i,
  output logic [ADDR_WIDTH-1:0] target_o
);

  logic [63:0]           offset_ext;
  logic [ADDR_WIDTH-1:0] offset_bytes;

  // Sign-extend before scaling so wide address spaces still see negative offsets.
  assign offset_ext   = {{32{branch_offset_i[31]}}, branch_offset_i} << 2;
  assign offset_bytes = offset_ext[ADDR_WIDTH-1:0];
  assign target_o     = branch_pc_i + offset_bytes;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, 1-cycle synchronous imem interface, single-entry stall
// hold buffer and the IF/ID register. FETCH_PERF_COUNTERS_EN adds fetch/bubble counters.
module instruction_fetch
  import arm_lp_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   stall,
  input  logic                   branchTaken,
  input  logic [ADDR_WIDTH-1:0]  branchPC,
  input  logic [31:0]            branchOffset,
  output logic [ADDR_WIDTH-1:0]  imemAddr,
  output logic                   imemReadEn,
  input  logic [INSTR_WIDTH-1:0] imemData,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  instrPC,
  output logic                   instrValid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]            fetchCount,
  output logic [31:0]            bubbleCount
`endif
);

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   fetch_en_q, fetch_en_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [ADDR_WIDTH-1:0]  pend_pc_q, pend_pc_d;
  logic                   hold_vld_q, hold_vld_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_WIDTH-1:0]  hold_pc_q, hold_pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
  logic                   instr_vld_q, instr_vld_d;
  fetch_state_e           state_q, state_d;

  logic [ADDR_WIDTH-1:0]  branch_target;
  logic                   read_en;

  branch_target_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_branch_target_calc (
    .branch_pc_i     (branchPC),
    .branch_offset_i (branchOffset),
    .target_o        (branch_target)
  );

  assign read_en     = fetch_en_q & ~stall & ~branchTaken;
  assign imemReadEn  = read_en;
  assign imemAddr    = pc_q;
  assign instruction = instr_q;
  assign instrPC     = instr_pc_q;
  assign instrValid  = instr_vld_q;

  always_comb begin
    pc_d         = pc_q;
    fetch_en_d   = 1'b1;
    pend_vld_d   = read_en;
    pend_pc_d    = pend_pc_q;
    hold_vld_d   = hold_vld_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    instr_vld_d  = instr_vld_q;
    state_d      = state_q;

    if (read_en) begin
      pc_d      = pc_q + ADDR_WIDTH'(4);
      pend_pc_d = pc_q;
    end

    if (branchTaken) begin
      // Redirect wins over stall; everything fetched down the old path is dropped.
      pc_d        = branch_target;
      instr_vld_d = 1'b0;
      instr_d     = NOP_INSTR;
      pend_vld_d  = 1'b0;
      hold_vld_d  = 1'b0;
      state_d     = FILL;
    end else if (stall) begin
      if (pend_vld_q) begin
        hold_instr_d = imemData;
        hold_pc_d    = pend_pc_q;
        hold_vld_d   = 1'b1;
        state_d      = HOLD;
      end
    end else if (hold_vld_q) begin
      instr_d     = hold_instr_q;
      instr_pc_d  = hold_pc_q;
      instr_vld_d = 1'b1;
      hold_vld_d  = 1'b0;
      state_d     = RUN;
    end else if (pend_vld_q) begin
      instr_d     = imemData;
      instr_pc_d  = pend_pc_q;
      instr_vld_d = 1'b1;
      state_d     = RUN;
    end else begin
      instr_vld_d = 1'b0;
      state_d     = FILL;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc_q         <= RESET_PC;
      fetch_en_q   <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_pc_q    <= '0;
      hold_vld_q   <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      instr_q      <= NOP_INSTR;
      instr_pc_q   <= '0;
      instr_vld_q  <= 1'b0;
      state_q      <= FILL;
    end else begin
      pc_q         <= pc_d;
      fetch_en_q   <= fetch_en_d;
      pend_vld_q   <= pend_vld_d;
      pend_pc_q    <= pend_pc_d;
      hold_vld_q   <= hold_vld_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      instr_vld_q  <= instr_vld_d;
      state_q      <= state_d;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        fetch_inc;
  logic        bubble_inc;

  // Mirrors the IF/ID load decisions above: a stalled edge loads nothing.
  assign fetch_inc  = ~branchTaken & ~stall & (hold_vld_q | pend_vld_q);
  assign bubble_inc = branchTaken | (~stall & ~hold_vld_q & ~pend_vld_q);

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (fetch_inc) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (bubble_inc) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetchCount  = fetch_cnt_q;
  assign bubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, stall/hold, branch,
// branch-during-hold, async mid-stream reset and PC wrap from a high RESET_PC.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetN, resetN2;
  logic        stall, branchTaken;
  logic [31:0] branchPC, branchOffset;
  logic [31:0] imemAddr, imemData, instruction, instrPC;
  logic        imemReadEn, instrValid;

  logic [31:0] imemAddr2, imemData2, instruction2, instrPC2;
  logic        imemReadEn2, instrValid2;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetchCount, bubbleCount, fetchCount2, bubbleCount2;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .resetN(resetN), .stall(stall), .branchTaken(branchTaken),
    .branchPC(branchPC), .branchOffset(branchOffset), .imemAddr(imemAddr),
    .imemReadEn(imemReadEn), .imemData(imemData), .instruction(instruction),
    .instrPC(instrPC), .instrValid(instrValid)
`ifdef FETCH_PERF_COUNTERS_EN
    , .fetchCount(fetchCount), .bubbleCount(bubbleCount)
`endif
  );

  instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .resetN(resetN2), .stall(zero1), .branchTaken(zero1),
    .branchPC(zero32), .branchOffset(zero32), .imemAddr(imemAddr2),
    .imemReadEn(imemReadEn2), .imemData(imemData2), .instruction(instruction2),
    .instrPC(instrPC2), .instrValid(instrValid2)
`ifdef FETCH_PERF_COUNTERS_EN
    , .fetchCount(fetchCount2), .bubbleCount(bubbleCount2)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8B00_0000 + {2'b00, a[31:2]};
  endfunction

  always @(posedge clock) begin
    if (imemReadEn)  imemData  <= mem_word(imemAddr);
    if (imemReadEn2) imemData2 <= mem_word(imemAddr2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    imemData = 32'h0; imemData2 = 32'h0;
    resetN = 1'b0; resetN2 = 1'b0;
    stall = 1'b0; branchTaken = 1'b0;
    branchPC = 32'h0; branchOffset = 32'h0;

    step(3);
    chk("rst_valid", {31'b0, instrValid}, 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc",    instrPC, 32'h0);
    chk("rst_addr",  imemAddr, 32'h0);
    chk("rst_rden",  {31'b0, imemReadEn}, 32'd0);

    @(negedge clock); resetN = 1'b1;
    step();
    chk("e1_rden",  {31'b0, imemReadEn}, 32'd1);
    chk("e1_valid", {31'b0, instrValid}, 32'd0);
    step();
    chk("e2_valid", {31'b0, instrValid}, 32'd0);
    chk("e2_addr",  imemAddr, 32'h4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("strm_valid", {31'b0, instrValid}, 32'd1);
      chk("strm_pc",    instrPC, 32'(4 * i));
      chk("strm_instr", instruction, 32'h8B00_0000 + 32'(i));
    end

    stall = 1'b1; #1;
    chk("stall_rden_comb", {31'b0, imemReadEn}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc",    instrPC, 32'h10);
      chk("stall_valid", {31'b0, instrValid}, 32'd1);
      chk("stall_rden",  {31'b0, imemReadEn}, 32'd0);
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("unstall_valid", {31'b0, instrValid}, 32'd1);
      chk("unstall_pc",    instrPC, 32'h14 + 32'(4 * i));
      chk("unstall_instr", instruction, 32'h8B00_0005 + 32'(i));
    end

    branchTaken = 1'b1; branchPC = 32'h20; branchOffset = 32'hFFFF_FFFE; #1;
    chk("br_rden_comb", {31'b0, imemReadEn}, 32'd0);
    step(); branchTaken = 1'b0;
    chk("br_addr",   imemAddr, 32'h18);
    chk("br_valid0", {31'b0, instrValid}, 32'd0);
    chk("br_instr0", instruction, 32'h0);
    step();
    chk("br_valid1", {31'b0, instrValid}, 32'd0);
    step();
    chk("br_tgt_valid", {31'b0, instrValid}, 32'd1);
    chk("br_tgt_pc",    instrPC, 32'h18);
    chk("br_tgt_instr", instruction, 32'h8B00_0006);
    step();
    chk("br_next_pc", instrPC, 32'h1C);

    stall = 1'b1;
    step();
    chk("hold_pc", instrPC, 32'h1C);
    branchTaken = 1'b1; branchPC = 32'h100; branchOffset = 32'h4;
    step(); branchTaken = 1'b0; stall = 1'b0;
    chk("brhold_valid0", {31'b0, instrValid}, 32'd0);
    chk("brhold_addr",   imemAddr, 32'h110);
    step();
    chk("brhold_valid1", {31'b0, instrValid}, 32'd0);
    step();
    chk("brhold_valid", {31'b0, instrValid}, 32'd1);
    chk("brhold_pc",    instrPC, 32'h110);
    chk("brhold_instr", instruction, 32'h8B00_0044);
    step();
    chk("brhold_next_pc", instrPC, 32'h114);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("perf_fetch",  fetchCount, 32'd12);
    chk("perf_bubble", bubbleCount, 32'd6);
`endif

    #2; resetN = 1'b0; #1;
    chk("arst_valid", {31'b0, instrValid}, 32'd0);
    chk("arst_instr", instruction, 32'h0);
    chk("arst_pc",    instrPC, 32'h0);
    chk("arst_addr",  imemAddr, 32'h0);
    chk("arst_rden",  {31'b0, imemReadEn}, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("arst_fetch",  fetchCount, 32'd0);
    chk("arst_bubble", bubbleCount, 32'd0);
`endif
    @(negedge clock); resetN = 1'b1;
    step(2);
    chk("restart_valid0", {31'b0, instrValid}, 32'd0);
    step();
    chk("restart_valid", {31'b0, instrValid}, 32'd1);
    chk("restart_pc",    instrPC, 32'h0);
    chk("restart_instr", instruction, 32'h8B00_0000);

    @(negedge clock); resetN2 = 1'b1;
    step(3);
    chk("wrap_valid", {31'b0, instrValid2}, 32'd1);
    chk("wrap_pc0",   instrPC2, 32'hFFFF_FFFC);
    chk("wrap_instr0", instruction2, 32'hCAFF_FFFF);
    step();
    chk("wrap_pc1",    instrPC2, 32'h0000_0000);
    chk("wrap_instr1", instruction2, 32'h8B00_0000);
    step();
    chk("wrap_pc2", instrPC2, 32'h0000_0004);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
